// File: rtl/pwm_fade_scheduler.sv
// Multi-channel LED fade sequencer: shared PWM timebase, per-channel ramp state,
// and one add/compare unit time-shared across channels by a scan FSM.
module pwm_fade_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int PERIOD_MAX = 245
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic [7:0]          cmd_target,
    input  logic [7:0]          cmd_step,
    output logic [8*NUM_CH-1:0] threshold_bus,
    output logic [NUM_CH-1:0]   busy,
    output logic                period_wrap
);

    localparam int CNT_W = $clog2(PERIOD_MAX + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    logic [CNT_W-1:0]    count_r;
    logic                wrap_r;
    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    idx_next_s;
    logic                scan_en_s;
    logic                ready_r;
    logic                accept_s;
    logic [7:0]          upd_s;
    logic [7:0]          cur_r  [NUM_CH];
    logic [7:0]          tgt_r  [NUM_CH];
    logic [7:0]          step_r [NUM_CH];
    logic [8*NUM_CH-1:0] thr_r;

    // One ramp step toward the target using 9-bit intermediates so neither
    // direction can wrap around the 8-bit range.
    function automatic logic [7:0] ramp_next(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] sum;
        logic [8:0] diff;
        logic [7:0] res;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (step == 8'd0) begin
            res = tgt;
        end else if (cur < tgt) begin
            res = (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
        end else if (cur > tgt) begin
            res = (diff[8] || (diff[7:0] <= tgt)) ? tgt : diff[7:0];
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign accept_s      = cmd_valid & ready_r;
    assign upd_s         = ramp_next(cur_r[idx_r], tgt_r[idx_r], step_r[idx_r]);
    assign cmd_ready     = ready_r;
    assign threshold_bus = thr_r;
    assign period_wrap   = wrap_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_busy
        assign busy[g] = (cur_r[g] != tgt_r[g]);
    end

    // Period counter; the wrap flag is precomputed so it is registered yet aligned with count==PERIOD_MAX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            count_r <= (count_r == CNT_W'(PERIOD_MAX)) ? {CNT_W{1'b0}} : count_r + CNT_W'(1);
            wrap_r  <= (count_r == CNT_W'(PERIOD_MAX - 1));
        end
    end

    // Scan FSM next-state: one channel per clock after each period wrap.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        scan_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (wrap_r) begin
                    state_next_s = SCAN;
                    idx_next_s   = {IDX_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                scan_en_s = 1'b1;
                if (idx_r == IDX_W'(NUM_CH - 1)) begin
                    state_next_s = IDLE;
                    idx_next_s   = {IDX_W{1'b0}};
                end else begin
                    idx_next_s = idx_r + IDX_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // FSM state register; ready is registered from the next state so it is low for exactly the scan.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            ready_r <= (state_next_s == IDLE);
        end
    end

    // Channel state: command writes, scan updates, and the period-boundary threshold load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            thr_r <= {(8*NUM_CH){1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                cur_r[i]  <= 8'd0;
                tgt_r[i]  <= 8'd0;
                step_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap_r) begin
                    thr_r[8*i +: 8] <= cur_r[i];
                end
                // Out-of-range channel indices match no entry and are dropped.
                if (accept_s && (cmd_ch == CH_W'(i))) begin
                    tgt_r[i]  <= cmd_target;
                    step_r[i] <= cmd_step;
                end
                if (scan_en_s && (idx_r == IDX_W'(i))) begin
                    cur_r[i] <= upd_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Self-checking bench for pwm_fade_scheduler: period-level reference model
// compared every cycle, plus directed literal expectations.
module tb_pwm_fade_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;
    localparam int PMAX   = 245;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [CH_W-1:0]     cmd_ch = '0;
    logic [7:0]          cmd_target = 8'd0;
    logic [7:0]          cmd_step = 8'd0;
    logic [8*NUM_CH-1:0] threshold_bus;
    logic [NUM_CH-1:0]   busy;
    logic                period_wrap;

    int checks = 0;
    int errors = 0;
    bit comp_en = 1'b0;

    pwm_fade_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD_MAX(PMAX)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step),
        .threshold_bus(threshold_bus), .busy(busy), .period_wrap(period_wrap)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_cur [NUM_CH];
    int m_tgt [NUM_CH];
    int m_step[NUM_CH];
    int m_thr [NUM_CH];
    int m_cnt;
    bit m_oor;
    bit m_seen;
    bit exp_rdy;

    assign exp_rdy = m_oor && !(m_seen && (m_cnt < NUM_CH));

    function automatic int ramp(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cur[i]  <= 0;
                m_tgt[i]  <= 0;
                m_step[i] <= 0;
                m_thr[i]  <= 0;
            end
            m_cnt  <= 0;
            m_oor  <= 1'b0;
            m_seen <= 1'b0;
        end else begin
            m_oor <= 1'b1;
            m_cnt <= (m_cnt == PMAX) ? 0 : m_cnt + 1;
            if (m_cnt == PMAX) begin
                m_seen <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) m_thr[i] <= m_cur[i];
            end
            if (exp_rdy && cmd_valid && (int'(cmd_ch) < NUM_CH)) begin
                m_tgt[int'(cmd_ch)]  <= int'(cmd_target);
                m_step[int'(cmd_ch)] <= int'(cmd_step);
            end
            if (m_seen && (m_cnt < NUM_CH))
                m_cur[m_cnt] <= ramp(m_cur[m_cnt], m_tgt[m_cnt], m_step[m_cnt]);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (comp_en) begin
            check("period_wrap", period_wrap, (m_cnt == PMAX) ? 1 : 0);
            check("cmd_ready", cmd_ready, exp_rdy);
            for (int i = 0; i < NUM_CH; i++) begin
                check($sformatf("thr%0d", i), threshold_bus[8*i +: 8], m_thr[i]);
                check($sformatf("busy%0d", i), busy[i], (m_cur[i] != m_tgt[i]) ? 1 : 0);
            end
        end
    end

    function automatic int thr(input int ch);
        return int'(threshold_bus[8*ch +: 8]);
    endfunction

    // Returns at the negedge just after the next threshold load
    task automatic wait_load();
        int n = 0;
        while (period_wrap !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("wrap_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send(input int ch, input int tgt, input int step);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_ch     = CH_W'(ch);
        cmd_target = 8'(tgt);
        cmd_step   = 8'(step);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        // 1: reset hold and release, wrap spacing
        repeat (5) @(negedge clk);
        comp_en = 1'b1;
        check("rst_thr", threshold_bus, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        reset = 1'b1;
        n = 0;
        while (period_wrap !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("first_wrap_seen", period_wrap, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (period_wrap !== 1'b1 && n < 400);
        check("wrap_interval", n, 246);
        @(negedge clk);

        // 2: jump
        send(1, 200, 0);
        wait_load();
        check("jump_k", thr(1), 0);
        wait_load();
        check("jump_k1", thr(1), 200);
        check("jump_busy", busy[1], 0);
        check("jump_ch0", thr(0), 0);

        // 3: ramp up
        send(0, 100, 30);
        wait_load();
        check("up_k", thr(0), 0);
        wait_load(); check("up_30", thr(0), 30);
        wait_load(); check("up_60", thr(0), 60);
        wait_load(); check("up_90", thr(0), 90);
        check("up_busy90", busy[0], 1);
        wait_load(); check("up_100", thr(0), 100);
        check("up_busy100", busy[0], 0);

        // 4: ramp down with clamp, overflow guard
        send(2, 250, 0);
        wait_load(); wait_load();
        check("dn_250", thr(2), 250);
        send(2, 5, 100);
        wait_load(); check("dn_k", thr(2), 250);
        wait_load(); check("dn_150", thr(2), 150);
        wait_load(); check("dn_50", thr(2), 50);
        wait_load(); check("dn_5", thr(2), 5);
        send(3, 10, 0);
        wait_load(); wait_load();
        check("ov_10", thr(3), 10);
        send(3, 255, 255);
        wait_load(); check("ov_k", thr(3), 10);
        wait_load(); check("ov_255", thr(3), 255);

        // 5: handshake held off during scan; out-of-range channel dropped
        wait_load();
        cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_target = 8'd77; cmd_step = 8'd0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("ready_low_clks", n, NUM_CH);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_load(); check("hs_k", thr(0), 100);
        wait_load(); check("hs_77", thr(0), 77);
        send(4, 123, 0);
        wait_load(); wait_load();
        check("oor_bus", threshold_bus, {8'd255, 8'd5, 8'd200, 8'd77});
        check("oor_busy", busy, 0);

        // 6: reset during scan
        send(0, 200, 10);
        wait_load(); check("mid_k", thr(0), 77);
        wait_load(); check("mid_87", thr(0), 87);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_thr", threshold_bus, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 0);
        reset = 1'b1;
        wait_load(); wait_load();
        check("post_rst_thr", threshold_bus, 0);
        check("post_rst_busy", busy, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
